// File: rtl/leitor_dht11.sv
// Single-wire DHT11-class reader: start pulse, response/bit timing, checksum check, fixed-point outputs.
// Latency: results and pronto appear the cycle after the checksum cycle; the line input adds 2 sync cycles.
// Backpressure: none; medir while busy is dropped, not queued.
module leitor_dht11 #(
    parameter int CLK_FREQ_HZ  = 50000000,
    parameter int START_LOW_US = 18000,
    parameter int TIMEOUT_US   = 200,
    parameter int THRESH_US    = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        dht_in,
    output logic        dht_oe,
    output logic [15:0] umidade,
    output logic [15:0] temperatura,
    output logic        pronto,
    output logic        erro,
    output logic        ocupado
);
    localparam int DIV  = CLK_FREQ_HZ / 1000000;
    localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PMAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int PW   = $clog2(PMAX + 1) + 1;

    typedef enum logic [2:0] {
        OCIOSO, INICIO, LIBERA, RESP_BAIXO, RESP_ALTO, BIT_BAIXO, BIT_ALTO, CHECA
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [2:0]      sinc_q;
    logic [DIVW-1:0] div_q;
    logic [PW-1:0]   fase_q, fase_d;
    logic [5:0]      idx_q, idx_d;
    logic [39:0]     quadro_q, quadro_d;
    logic [15:0]     umid_q, umid_d, temp_q, temp_d;
    logic            pronto_q, pronto_d, erro_q, erro_d;

    logic tick, sobe, desce, fim_inicio, estouro, bit_val;
    logic [7:0] soma;

    // sinc_q[1] is the synchronised line, sinc_q[2] its previous value for edge detection
    assign sobe       = sinc_q[1] & ~sinc_q[2];
    assign desce      = ~sinc_q[1] & sinc_q[2];
    assign tick       = (div_q == DIVW'(DIV - 1));
    // Counting ticks: the phase count reaches N on the tick that would make it N
    assign fim_inicio = tick && (fase_q == PW'(START_LOW_US - 1));
    assign estouro    = tick && (fase_q == PW'(TIMEOUT_US - 1));
    assign bit_val    = (fase_q > PW'(THRESH_US));
    assign soma       = quadro_q[39:32] + quadro_q[31:24] + quadro_q[23:16] + quadro_q[15:8];

    assign dht_oe      = (estado_q == INICIO);
    assign ocupado     = (estado_q != OCIOSO);
    assign umidade     = umid_q;
    assign temperatura = temp_q;
    assign pronto      = pronto_q;
    assign erro        = erro_q;

    // Next-state logic: edge-driven phases with a common timeout, checksum check in CHECA
    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        quadro_d = quadro_q;
        umid_d   = umid_q;
        temp_d   = temp_q;
        pronto_d = 1'b0;
        erro_d   = erro_q;
        case (estado_q)
            OCIOSO: begin
                if (medir) begin
                    estado_d = INICIO;
                    erro_d   = 1'b0;
                end
            end
            INICIO: begin
                if (fim_inicio) estado_d = LIBERA;
            end
            LIBERA, RESP_BAIXO, RESP_ALTO, BIT_BAIXO, BIT_ALTO: begin
                if (estouro) begin
                    erro_d   = 1'b1;
                    estado_d = OCIOSO;
                end else begin
                    case (estado_q)
                        LIBERA:     if (desce) estado_d = RESP_BAIXO;
                        RESP_BAIXO: if (sobe)  estado_d = RESP_ALTO;
                        RESP_ALTO: begin
                            if (desce) begin
                                estado_d = BIT_BAIXO;
                                idx_d    = 6'd0;
                            end
                        end
                        BIT_BAIXO:  if (sobe)  estado_d = BIT_ALTO;
                        default: begin
                            if (desce) begin
                                quadro_d = {quadro_q[38:0], bit_val};
                                if (idx_q == 6'd39) begin
                                    estado_d = CHECA;
                                end else begin
                                    idx_d    = idx_q + 6'd1;
                                    estado_d = BIT_BAIXO;
                                end
                            end
                        end
                    endcase
                end
            end
            CHECA: begin
                if (soma == quadro_q[7:0]) begin
                    umid_d   = quadro_q[39:24];
                    temp_d   = quadro_q[23:8];
                    pronto_d = 1'b1;
                end else begin
                    erro_d = 1'b1;
                end
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // Phase counter restarts on every state change and is held at zero while idle
    always_comb begin
        fase_d = fase_q;
        if ((estado_d != estado_q) || (estado_q == OCIOSO)) begin
            fase_d = '0;
        end else if (tick) begin
            fase_d = fase_q + PW'(1);
        end
    end

    // State, timebase, synchroniser and result registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            sinc_q   <= '0;
            div_q    <= '0;
            fase_q   <= '0;
            idx_q    <= '0;
            quadro_q <= '0;
            umid_q   <= '0;
            temp_q   <= '0;
            pronto_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            sinc_q   <= {sinc_q[1:0], dht_in};
            div_q    <= tick ? '0 : div_q + DIVW'(1);
            fase_q   <= fase_d;
            idx_q    <= idx_d;
            quadro_q <= quadro_d;
            umid_q   <= umid_d;
            temp_q   <= temp_d;
            pronto_q <= pronto_d;
            erro_q   <= erro_d;
        end
    end
endmodule

// File: tb/tb_leitor_dht11.sv
`timescale 1ns/1ps
module tb_leitor_dht11;
    localparam int START_LOW = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        medir = 1'b0;
    logic        sens_low = 1'b0;
    logic        dht_in;
    logic        dht_oe;
    logic [15:0] umidade, temperatura;
    logic        pronto, erro, ocupado;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          err;
        logic [15:0] h;
        logic [15:0] t;
    } exp_t;
    exp_t exp_q[$];

    // Reference state: last published values
    logic [15:0] ref_h = 16'h0, ref_t = 16'h0;

    // Open-drain line with pull-up: low if host or sensor pulls it
    assign dht_in = ~(dht_oe | sens_low);

    always #500 clock = ~clock;

    leitor_dht11 #(
        .CLK_FREQ_HZ (1000000),
        .START_LOW_US(START_LOW),
        .TIMEOUT_US  (200),
        .THRESH_US   (50)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .medir      (medir),
        .dht_in     (dht_in),
        .dht_oe     (dht_oe),
        .umidade    (umidade),
        .temperatura(temperatura),
        .pronto     (pronto),
        .erro       (erro),
        .ocupado    (ocupado)
    );

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: every pronto pulse or new erro is matched against the oldest expectation
    task automatic monitor();
        logic erro_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                erro_prev = 1'b0;
                continue;
            end
            if (pronto || (erro && !erro_prev)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {39'd0, pronto}, 40'd2);
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_error", {39'd0, ~pronto}, {39'd0, e.err});
                    check("umidade", {24'd0, umidade}, {24'd0, e.h});
                    check("temperatura", {24'd0, temperatura}, {24'd0, e.t});
                    if (pronto) check("erro_with_pronto", {39'd0, erro}, 40'd0);
                end
            end
            erro_prev = erro;
        end
    endtask

    // One measurement: nbits<0 means the sensor stays silent; poke pulses medir mid-frame
    task automatic medida(input logic [39:0] f, input int nbits, input bit poke);
        int   n;
        int   s;
        exp_t e;
        s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
        if (nbits == 40 && (s % 256) == int'(f[7:0])) begin
            ref_h = f[39:24];
            ref_t = f[23:8];
            e = '{err: 1'b0, h: ref_h, t: ref_t};
        end else begin
            e = '{err: 1'b1, h: ref_h, t: ref_t};
        end
        exp_q.push_back(e);

        medir = 1'b1;
        cyc(1);
        medir = 1'b0;
        n = 0;
        while (dht_oe && n < 100) begin
            n++;
            cyc(1);
        end
        check("oe_low_time", 40'(n), 40'(START_LOW));

        if (nbits < 0) begin
            n = 0;
            while (!erro && n < 300) begin
                cyc(1);
                n++;
            end
            check("silent_timeout_us", 40'(n), 40'd200);
            check("silent_ocupado", {39'd0, ocupado}, 40'd0);
            check("silent_oe", {39'd0, dht_oe}, 40'd0);
        end else begin
            cyc(30);
            sens_low = 1'b1; cyc(80);
            sens_low = 1'b0; cyc(80);
            for (int i = 0; i < nbits; i++) begin
                sens_low = 1'b1;
                if (poke && i == 10) medir = 1'b1;
                cyc(50);
                medir = 1'b0;
                sens_low = 1'b0;
                cyc(f[39 - i] ? 70 : 27);
            end
            if (nbits == 40) begin
                sens_low = 1'b1; cyc(50);
                sens_low = 1'b0;
            end
        end
        n = 0;
        while (ocupado && n < 400) begin
            cyc(1);
            n++;
        end
        check("returns_idle", {39'd0, ocupado}, 40'd0);
        cyc(3);
        check("event_seen", 40'(exp_q.size()), 40'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0]  b4, b3, b2, b1, sm;
        fork
            monitor();
        join_none

        cyc(3);
        check("rst_oe", {39'd0, dht_oe}, 40'd0);
        check("rst_umidade", {24'd0, umidade}, 40'd0);
        check("rst_temperatura", {24'd0, temperatura}, 40'd0);
        check("rst_pronto", {39'd0, pronto}, 40'd0);
        check("rst_erro", {39'd0, erro}, 40'd0);
        check("rst_ocupado", {39'd0, ocupado}, 40'd0);
        reset = 1'b1;
        cyc(3);

        medida(40'h3700190353, 40, 1'b0);
        medida(40'h3700190354, 40, 1'b0);
        medida(40'h0, -1, 1'b0);
        medida(40'h3700190353, 17, 1'b0);
        medida(40'h40001A005A, 40, 1'b0);
        check("erro_cleared", {39'd0, erro}, 40'd0);
        medida(40'h2201180542, 40, 1'b1);

        for (int k = 0; k < 4; k++) begin
            b4 = 8'($urandom_range(0, 255));
            b3 = 8'($urandom_range(0, 255));
            b2 = 8'($urandom_range(0, 255));
            b1 = 8'($urandom_range(0, 255));
            sm = b4 + b3 + b2 + b1;
            if ($urandom_range(0, 2) == 0) sm = sm ^ 8'($urandom_range(1, 255));
            medida({b4, b3, b2, b1, sm}, 40, 1'b0);
        end

        // Reset in the middle of the start pulse
        medir = 1'b1;
        cyc(1);
        medir = 1'b0;
        cyc(5);
        check("inicio_oe", {39'd0, dht_oe}, 40'd1);
        #100 reset = 1'b0;
        ref_h = 16'h0;
        ref_t = 16'h0;
        #1;
        check("midrst_oe", {39'd0, dht_oe}, 40'd0);
        check("midrst_umidade", {24'd0, umidade}, 40'd0);
        check("midrst_temperatura", {24'd0, temperatura}, 40'd0);
        check("midrst_pronto", {39'd0, pronto}, 40'd0);
        check("midrst_erro", {39'd0, erro}, 40'd0);
        check("midrst_ocupado", {39'd0, ocupado}, 40'd0);
        cyc(2);
        reset = 1'b1;
        cyc(3);
        check("post_rst_ocupado", {39'd0, ocupado}, 40'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
